// File: rtl/mips_isa_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_isa_pkg
// Purpose  : MIPS opcode/func constants and instruction-format classification
//            shared by the program loader and the controller.
// Revision : 1.0 - initial release
// ============================================================================
package mips_isa_pkg;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_JAL   = 6'd3;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_BNE   = 6'd5;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_SLTI  = 6'd10;
    localparam logic [5:0] OP_ANDI  = 6'd12;
    localparam logic [5:0] OP_ORI   = 6'd13;
    localparam logic [5:0] OP_LUI   = 6'd15;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    localparam logic [5:0] FN_SLL   = 6'd0;
    localparam logic [5:0] FN_SRL   = 6'd2;
    localparam logic [5:0] FN_JR    = 6'd8;
    localparam logic [5:0] FN_ADD   = 6'd32;
    localparam logic [5:0] FN_SUB   = 6'd34;
    localparam logic [5:0] FN_AND   = 6'd36;
    localparam logic [5:0] FN_OR    = 6'd37;
    localparam logic [5:0] FN_SLT   = 6'd42;

    typedef enum logic [1:0] {
        FMT_R   = 2'd0,
        FMT_I   = 2'd1,
        FMT_J   = 2'd2,
        FMT_BAD = 2'd3
    } instr_fmt_t;

    function automatic instr_fmt_t opcode_fmt(input logic [5:0] op);
        instr_fmt_t f;
        case (op)
            OP_RTYPE:                          f = FMT_R;
            OP_J, OP_JAL:                      f = FMT_J;
            OP_BEQ, OP_BNE, OP_ADDI, OP_SLTI,
            OP_ANDI, OP_ORI, OP_LUI, OP_LW,
            OP_SW:                             f = FMT_I;
            default:                           f = FMT_BAD;
        endcase
        return f;
    endfunction

endpackage
`default_nettype wire

// File: rtl/instr_format_encoder.sv
`default_nettype none
// ============================================================================
// Module   : instr_format_encoder
// Purpose  : Packs instruction fields into a 32-bit MIPS word by format.
// Revision : 1.0 - initial release
// ============================================================================
module instr_format_encoder
    import mips_isa_pkg::*;
(
    input  logic [5:0]  opcode,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [4:0]  shamt,
    input  logic [5:0]  func,
    input  logic [15:0] imm,
    input  logic [25:0] target,
    output instr_fmt_t  fmt,
    output logic [31:0] word
);

    always_comb begin
        fmt  = opcode_fmt(opcode);
        word = 32'd0;
        case (fmt)
            FMT_R:   word = {opcode, rs, rt, rd, shamt, func};
            FMT_I:   word = {opcode, rs, rt, imm};
            FMT_J:   word = {opcode, target};
            default: word = 32'd0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/imem_program_loader.sv
`default_nettype none
// ============================================================================
// Module   : imem_program_loader
// Purpose  : Accepts field-level instruction requests and writes encoded words
//            to consecutive instruction-memory addresses.
// Revision : 1.0 - initial release
// ============================================================================
module imem_program_loader
    import mips_isa_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [5:0]        in_opcode,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_shamt,
    input  logic [5:0]        in_func,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    input  logic              in_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err_unsupported,
    output logic              err_overflow,
    output logic [ADDR_W:0]   word_count
);

    localparam int DEPTH = 2 ** ADDR_W;

    localparam logic [ADDR_W:0]   c_depth    = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   c_last_cnt = (ADDR_W + 1)'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] c_base     = ADDR_W'(BASE_ADDR);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_DRAIN = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_OVF   = 3'd4;

    logic [2:0]        r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W:0]   r_word_count;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [31:0]       r_mem_wdata;
    logic              r_done;
    logic              r_err_unsupported;
    logic              r_err_overflow;

    instr_fmt_t        w_fmt;
    logic [31:0]       w_word;
    logic              w_accept;
    logic              w_supported;

    instr_format_encoder u_encoder (
        .opcode (in_opcode),
        .rs     (in_rs),
        .rt     (in_rt),
        .rd     (in_rd),
        .shamt  (in_shamt),
        .func   (in_func),
        .imm    (in_imm),
        .target (in_target),
        .fmt    (w_fmt),
        .word   (w_word)
    );

    assign in_ready    = (r_state == S_LOAD) && (r_word_count < c_depth);
    assign w_accept    = in_valid && in_ready;
    assign w_supported = (w_fmt != FMT_BAD);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state           <= S_IDLE;
            r_addr            <= c_base;
            r_word_count      <= '0;
            r_mem_we          <= 1'b0;
            r_mem_addr        <= '0;
            r_mem_wdata       <= 32'd0;
            r_done            <= 1'b0;
            r_err_unsupported <= 1'b0;
            r_err_overflow    <= 1'b0;
        end else begin
            r_mem_we <= 1'b0;
            r_done   <= 1'b0;
            case (r_state)
                S_IDLE, S_OVF: begin
                    if (start) begin
                        r_state           <= S_LOAD;
                        r_addr            <= c_base;
                        r_word_count      <= '0;
                        r_err_unsupported <= 1'b0;
                        r_err_overflow    <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (w_accept) begin
                        if (w_supported) begin
                            r_mem_we     <= 1'b1;
                            r_mem_addr   <= r_addr;
                            r_mem_wdata  <= w_word;
                            r_addr       <= r_addr + 1'b1;
                            r_word_count <= r_word_count + 1'b1;
                        end else begin
                            r_err_unsupported <= 1'b1;
                        end
                        // in_last takes priority over filling the last slot
                        if (in_last) begin
                            r_state <= S_DRAIN;
                        end else if (w_supported && (r_word_count == c_last_cnt)) begin
                            r_state        <= S_OVF;
                            r_err_overflow <= 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    r_state <= S_DONE;
                    r_done  <= 1'b1;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy            = (r_state == S_LOAD) || (r_state == S_DRAIN);
    assign mem_we          = r_mem_we;
    assign mem_addr        = r_mem_addr;
    assign mem_wdata       = r_mem_wdata;
    assign done            = r_done;
    assign err_unsupported = r_err_unsupported;
    assign err_overflow    = r_err_overflow;
    assign word_count      = r_word_count;

endmodule
`default_nettype wire

// File: tb/tb_imem_program_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_program_loader
// Purpose  : Scoreboard bench for imem_program_loader with a 4-word memory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imem_program_loader;

    localparam int ADDR_W = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              in_valid;
    logic              in_ready;
    logic [5:0]        in_opcode;
    logic [4:0]        in_rs, in_rt, in_rd, in_shamt;
    logic [5:0]        in_func;
    logic [15:0]       in_imm;
    logic [25:0]       in_target;
    logic              in_last;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              busy, done, err_unsupported, err_overflow;
    logic [ADDR_W:0]   word_count;

    imem_program_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(0)) dut (
        .clk(clk), .rst(rst), .start(start),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .in_shamt(in_shamt), .in_func(in_func), .in_imm(in_imm),
        .in_target(in_target), .in_last(in_last),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .busy(busy), .done(done), .err_unsupported(err_unsupported),
        .err_overflow(err_overflow), .word_count(word_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    wr_t    exp_q[$];
    int     tests = 0;
    int     fails = 0;
    int     exp_addr = 0;
    int     done_seen = 0;
    int     exp_done = 0;
    int     cyc = 0;
    int     last_wr_cyc = -100;
    int     wr_gap = 0;
    logic   prev_done = 1'b0;

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Monitor: compare every write against the scoreboard, track done pulses
    always @(negedge clk) begin
        if (mem_we) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", {mem_addr, mem_wdata}, 0);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", mem_addr, e.addr);
                check("wr_data", mem_wdata, e.data);
            end
            wr_gap      = cyc - last_wr_cyc;
            last_wr_cyc = cyc;
        end
        if (done) begin
            done_seen++;
            if (prev_done) check("done_width", 2, 1);
        end
        prev_done = done;
    end

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        exp_addr = 0;
    endtask

    // Present one request until accepted; push expected write if supported
    task automatic issue(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn,
                         input logic [15:0] imm, input logic [25:0] tgt, input logic last,
                         input logic sup, input logic [31:0] exp_word);
        logic rdy;
        int   n;
        wr_t  w;
        in_opcode = op; in_rs = rs; in_rt = rt; in_rd = rd; in_shamt = sh;
        in_func = fn; in_imm = imm; in_target = tgt; in_last = last;
        in_valid = 1'b1;
        if (sup) begin
            w.addr = exp_addr[ADDR_W-1:0];
            w.data = exp_word;
            exp_q.push_back(w);
            exp_addr++;
        end
        n = 0;
        do begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk); #1;
            n++;
        end while (!rdy && n < 20);
        if (!rdy) check("accept_timeout", 0, 1);
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_done(input int exp_wc);
        int  n;
        logic seen;
        seen = 1'b0;
        n = 0;
        while (!seen && n < 10) begin
            @(negedge clk);
            #1;
            if (done) seen = 1'b1;
            n++;
        end
        exp_done++;
        check("done_seen", seen, 1);
        check("done_word_count", word_count, exp_wc);
        @(negedge clk);
        check("idle_after_done", {busy, done}, 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        in_opcode = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_shamt = '0;
        in_func = '0; in_imm = '0; in_target = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_outputs",
              {in_ready, mem_we, mem_addr, mem_wdata, busy, done, err_unsupported, err_overflow, word_count},
              0);

        // Single R-type with last
        pulse_start();
        issue(6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'd32, 16'h0, 26'h0, 1'b1, 1'b1, 32'h00221820);
        idle_inputs();
        @(negedge clk);
        check("drain_busy", {busy, done}, 2'b10);
        wait_done(1);

        // sw then j back-to-back; J fields rd/func ignored
        pulse_start();
        issue(6'd43, 5'd4, 5'd5, 5'd0, 5'd0, 6'd0, 16'd8, 26'h0, 1'b0, 1'b1, 32'hAC850008);
        issue(6'd2, 5'd0, 5'd0, 5'd31, 5'd7, 6'd63, 16'hFFFF, 26'h100, 1'b1, 1'b1, 32'h08000100);
        idle_inputs();
        wait_done(2);
        check("back_to_back_gap", wr_gap, 1);

        // addi, unsupported 63, ori
        pulse_start();
        issue(6'd8, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'd5, 26'h0, 1'b0, 1'b1, 32'h20220005);
        check("unsup_before", err_unsupported, 0);
        issue(6'd63, 5'd1, 5'd1, 5'd1, 5'd1, 6'd1, 16'd1, 26'h1, 1'b0, 1'b0, 32'h0);
        check("unsup_set", err_unsupported, 1);
        issue(6'd13, 5'd3, 5'd4, 5'd0, 5'd0, 6'd0, 16'h00FF, 26'h0, 1'b1, 1'b1, 32'h346400FF);
        idle_inputs();
        wait_done(2);
        check("unsup_sticky", err_unsupported, 1);

        // Overflow: fill 4 words without last
        pulse_start();
        check("unsup_cleared", err_unsupported, 0);
        for (int i = 0; i < 4; i++) begin
            issue(6'd15, 5'd0, 5'(i), 5'd0, 5'd0, 6'd0, 16'(i + 1), 26'h0, 1'b0, 1'b1,
                  32'h3C000000 | (32'(i) << 16) | 32'(i + 1));
        end
        in_valid = 1'b1;
        in_opcode = 6'd15;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("ovf_ready_low", in_ready, 0);
        end
        check("ovf_flag", err_overflow, 1);
        check("ovf_count", word_count, 4);
        check("ovf_not_busy", busy, 0);
        idle_inputs();
        check("ovf_no_done", done_seen, exp_done);
        pulse_start();
        check("restart_clear", {err_overflow, err_unsupported, word_count}, 0);
        issue(6'd35, 5'd9, 5'd10, 5'd0, 5'd0, 6'd0, 16'h0010, 26'h0, 1'b1, 1'b1, 32'h8D2A0010);
        idle_inputs();
        wait_done(1);

        // Reset mid-LOAD after two accepts
        pulse_start();
        issue(6'd4, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'hFFFE, 26'h0, 1'b0, 1'b1, 32'h1022FFFE);
        issue(6'd5, 5'd3, 5'd4, 5'd0, 5'd0, 6'd0, 16'h0002, 26'h0, 1'b0, 1'b1, 32'h14640002);
        idle_inputs();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_outputs",
              {in_ready, mem_we, mem_addr, mem_wdata, busy, done, err_unsupported, err_overflow, word_count},
              0);
        pulse_start();
        issue(6'd3, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'h0, 26'h0ABCDE, 1'b1, 1'b1, 32'h0C0ABCDE);
        idle_inputs();
        wait_done(1);

        // start pulsed while in LOAD is ignored
        pulse_start();
        issue(6'd12, 5'd1, 5'd1, 5'd0, 5'd0, 6'd0, 16'h000F, 26'h0, 1'b0, 1'b1, 32'h3021000F);
        start = 1'b1;
        issue(6'd10, 5'd2, 5'd3, 5'd0, 5'd0, 6'd0, 16'h0004, 26'h0, 1'b0, 1'b1, 32'h28430004);
        start = 1'b0;
        check("start_ignored_count", word_count, 2);
        issue(6'd0, 5'd4, 5'd5, 5'd6, 5'd2, 6'd42, 16'h0, 26'h0, 1'b1, 1'b1, 32'h008530AA);
        idle_inputs();
        wait_done(3);

        // in_last on the filling accept: done wins over overflow
        pulse_start();
        for (int i = 0; i < 4; i++) begin
            issue(6'd8, 5'd0, 5'd1, 5'd0, 5'd0, 6'd0, 16'(i), 26'h0, (i == 3), 1'b1,
                  32'h20010000 | 32'(i));
        end
        idle_inputs();
        wait_done(4);
        check("fill_last_no_ovf", err_overflow, 0);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);
        check("done_total", done_seen, exp_done);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
